// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared SCCB/I2C types and constants
package sccb_pkg;

    localparam logic [6:0] OV7670_ADDR_7BIT = 7'h21;
    localparam logic       MODE_I2C         = 1'b0;
    localparam logic       MODE_SCCB        = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEV_ADDR,
        S_DEV_ACK,
        S_REG_ADDR,
        S_REG_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_IGNORE
    } state_t;

endpackage

// File: rtl/sccb_line_sync.sv
// rtl/sccb_line_sync.sv - SCL/SDA synchronizer with edge, START and STOP pulses
module sccb_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_pipe_q;
    logic [SYNC_STAGES-1:0] sda_pipe_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_pipe_q <= '1;
            sda_pipe_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_pipe_q <= {scl_pipe_q[SYNC_STAGES-2:0], scl_i};
            sda_pipe_q <= {sda_pipe_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s      = scl_pipe_q[SYNC_STAGES-1];
    assign sda_s      = sda_pipe_q[SYNC_STAGES-1];
    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/sccb_target_regfile.sv
// rtl/sccb_target_regfile.sv - SCCB/I2C target with a 256x8 register file
// Write bursts land in the file with a strobe; reads stream from the pointer.
module sccb_target_regfile
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = OV7670_ADDR_7BIT,
    parameter bit         ACK_EN      = 1'b1,
    parameter bit         AUTO_INC    = 1'b0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCL,
    inout  wire        SDA,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_rdata,
    output logic       busy,
    output logic       addr_hit
);

    logic sda_s, scl_rise, scl_fall, start_p, stop_p;

    sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (SCL),
        .sda_i      (SDA),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_p),
        .stop_o     (stop_p)
    );

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       ack_ph_q, ack_ph_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       hit_q, hit_d;
    logic       wr_valid_q, wr_valid_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] rd_q;
    logic [7:0] dbg_q;
    logic [7:0] mem [256];
    logic [7:0] byte_in;
    logic [7:0] inc;

    assign byte_in = {shift_q[6:0], sda_s};
    assign inc     = AUTO_INC ? 8'd1 : 8'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            ack_ph_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            hit_q      <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_q       <= '0;
            dbg_q      <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            ack_ph_q   <= ack_ph_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            hit_q      <= hit_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_q       <= mem[ptr_q];
            dbg_q      <= mem[dbg_addr];
            if (wr_valid_d) mem[ptr_q] <= byte_in;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        ack_ph_d   = ack_ph_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        hit_d      = 1'b0;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (start_p) begin
            state_d  = S_DEV_ADDR;
            cnt_d    = '0;
            ack_ph_d = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
        end else if (stop_p) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            ack_ph_d = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = '0;
                            case (state_q)
                                S_DEV_ADDR: begin
                                    if (byte_in[7:1] == DEV_ADDR) begin
                                        hit_d   = 1'b1;
                                        rw_d    = byte_in[0];
                                        state_d = S_DEV_ACK;
                                    end else begin
                                        state_d = S_IGNORE;
                                    end
                                end
                                S_REG_ADDR: begin
                                    ptr_d   = byte_in;
                                    state_d = S_REG_ACK;
                                end
                                default: begin
                                    wr_valid_d = 1'b1;
                                    wr_addr_d  = ptr_q;
                                    wr_data_d  = byte_in;
                                    ptr_d      = ptr_q + inc;
                                    state_d    = S_WR_ACK;
                                end
                            endcase
                        end
                    end
                end
                // First fall drives the ACK, second fall releases it and moves on.
                S_DEV_ACK, S_REG_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_ph_q) begin
                            ack_ph_d = 1'b1;
                            sda_oe_d = ACK_EN;
                        end else begin
                            ack_ph_d = 1'b0;
                            sda_oe_d = 1'b0;
                            if (state_q == S_DEV_ACK && rw_q) begin
                                state_d  = S_RD_DATA;
                                shift_d  = rd_q;
                                sda_oe_d = ~rd_q[7];
                                cnt_d    = 4'd1;
                            end else if (state_q == S_DEV_ACK) begin
                                state_d = S_REG_ADDR;
                            end else begin
                                state_d = S_WR_DATA;
                            end
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = S_RD_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[6];
                            shift_d  = {shift_q[6:0], 1'b0};
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise && !ack_ph_q) begin
                        if (sda_s) begin
                            state_d = S_IGNORE;
                        end else begin
                            ack_ph_d = 1'b1;
                            ptr_d    = ptr_q + inc;
                        end
                    end else if (scl_fall && ack_ph_q) begin
                        ack_ph_d = 1'b0;
                        state_d  = S_RD_DATA;
                        shift_d  = rd_q;
                        sda_oe_d = ~rd_q[7];
                        cnt_d    = 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_valid  = wr_valid_q;
        wr_addr   = wr_addr_q;
        wr_data   = wr_data_q;
        dbg_rdata = dbg_q;
        busy      = busy_q;
        addr_hit  = hit_q;
    end

    assign SDA = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_sccb_target_regfile.sv
// tb/tb_sccb_target_regfile.sv - directed bit-banged master against the SCCB target
module tb_sccb_target_regfile;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] dbg_addr = 8'h00;
    wire        sda;
    logic       wr_valid, busy, addr_hit;
    logic [7:0] wr_addr, wr_data, dbg_rdata;

    int passed = 0;
    int total = 0;
    int wr_cnt = 0;
    int hit_cnt = 0;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] last_data = 8'h00;
    logic       dut_low_seen = 1'b0;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    sccb_target_regfile #(
        .DEV_ADDR    (7'h21),
        .ACK_EN      (1'b1),
        .AUTO_INC    (1'b1),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .SCL       (scl),
        .SDA       (sda),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata),
        .busy      (busy),
        .addr_hit  (addr_hit)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt++;
            last_addr = wr_addr;
            last_data = wr_data;
        end
        if (addr_hit) hit_cnt++;
        if (sda === 1'b0 && !m_low) dut_low_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic qwait();
        repeat (8) @(posedge clk);
    endtask

    task automatic i2c_start();
        m_low = 1'b0; qwait();
        scl = 1'b1;   qwait();
        m_low = 1'b1; qwait();
        scl = 1'b0;   qwait();
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; qwait();
        scl = 1'b1;   qwait();
        m_low = 1'b0; qwait();
    endtask

    task automatic write_bit(input logic b);
        m_low = ~b; qwait();
        scl = 1'b1; qwait(); qwait();
        scl = 1'b0; qwait();
    endtask

    task automatic read_bit(output logic b);
        m_low = 1'b0; qwait();
        scl = 1'b1;   qwait();
        b = (sda === 1'b0) ? 1'b0 : 1'b1;
        qwait();
        scl = 1'b0;   qwait();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic dbg_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk) dbg_addr = a;
        @(negedge clk) d = dbg_rdata;
    endtask

    initial begin
        logic       ack;
        logic       a0, a1, a2;
        logic [7:0] rd;
        logic [7:0] r0, r1, r2;
        int         wr_before, hit_before;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_wr_valid", wr_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_addr_hit", addr_hit, 1'b0);
        check("reset_sda_released", sda, 1'b1);
        reset = 1'b0;
        dbg_read(8'h12, rd);
        check("reset_regfile", rd, 8'h00);

        // single write 0x12 = 0x80
        i2c_start();
        repeat (4) @(negedge clk);
        check("busy_after_start", busy, 1'b1);
        write_byte(8'h42, a0);
        write_byte(8'h12, a1);
        write_byte(8'h80, a2);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("w1_dev_ack", a0, 1'b0);
        check("w1_reg_ack", a1, 1'b0);
        check("w1_data_ack", a2, 1'b0);
        check("w1_wr_cnt", wr_cnt, 1);
        check("w1_wr_addr", last_addr, 8'h12);
        check("w1_wr_data", last_data, 8'h80);
        check("w1_hit_cnt", hit_cnt, 1);
        check("busy_after_stop", busy, 1'b0);
        dbg_read(8'h12, rd);
        check("w1_dbg", rd, 8'h80);

        // write 0x3A = 0x04, then two-phase read
        i2c_start();
        write_byte(8'h42, ack);
        write_byte(8'h3A, ack);
        write_byte(8'h04, ack);
        i2c_stop();
        i2c_start();
        write_byte(8'h42, ack);
        write_byte(8'h3A, ack);
        i2c_stop();
        i2c_start();
        write_byte(8'h43, a0);
        read_byte(rd, 1'b1);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("r2_dev_ack", a0, 1'b0);
        check("r2_data", rd, 8'h04);
        check("r2_sda_released", sda, 1'b1);
        check("r2_wr_cnt", wr_cnt, 2);

        // foreign address 0x22 is ignored
        wr_before    = wr_cnt;
        hit_before   = hit_cnt;
        dut_low_seen = 1'b0;
        i2c_start();
        write_byte(8'h44, a0);
        write_byte(8'h12, a1);
        write_byte(8'h55, a2);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("x3_dev_nack", a0, 1'b1);
        check("x3_data_nack", a2, 1'b1);
        check("x3_no_hit", hit_cnt, hit_before);
        check("x3_never_low", dut_low_seen, 1'b0);
        check("x3_no_write", wr_cnt, wr_before);
        dbg_read(8'h12, rd);
        check("x3_regfile_kept", rd, 8'h80);

        // burst write across the 0xFF -> 0x00 wrap
        wr_before = wr_cnt;
        i2c_start();
        write_byte(8'h42, ack);
        write_byte(8'hFE, ack);
        write_byte(8'hA5, ack);
        write_byte(8'h5A, ack);
        write_byte(8'hC3, ack);
        i2c_stop();
        check("b4_wr_cnt", wr_cnt, wr_before + 3);
        check("b4_last_addr", last_addr, 8'h00);
        dbg_read(8'hFE, rd);
        check("b4_fe", rd, 8'hA5);
        dbg_read(8'hFF, rd);
        check("b4_ff", rd, 8'h5A);
        dbg_read(8'h00, rd);
        check("b4_00", rd, 8'hC3);

        // burst read with ACK, ACK, NACK across the wrap
        i2c_start();
        write_byte(8'h42, ack);
        write_byte(8'hFE, ack);
        i2c_stop();
        i2c_start();
        write_byte(8'h43, ack);
        read_byte(r0, 1'b0);
        read_byte(r1, 1'b0);
        read_byte(r2, 1'b1);
        i2c_stop();
        check("rb_fe", r0, 8'hA5);
        check("rb_ff", r1, 8'h5A);
        check("rb_00", r2, 8'hC3);

        // aborted data byte, then repeated START mid register address
        wr_before = wr_cnt;
        i2c_start();
        write_byte(8'h42, ack);
        write_byte(8'h10, ack);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_stop();
        check("a5_no_partial_write", wr_cnt, wr_before);
        i2c_start();
        write_byte(8'h42, ack);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_start();
        write_byte(8'h42, a0);
        write_byte(8'h20, a1);
        write_byte(8'h99, a2);
        i2c_stop();
        check("a5_restart_ack", a0, 1'b0);
        check("a5_wr_cnt", wr_cnt, wr_before + 1);
        check("a5_wr_addr", last_addr, 8'h20);
        check("a5_wr_data", last_data, 8'h99);
        dbg_read(8'h10, rd);
        check("a5_reg10_kept", rd, 8'h00);

        // reset while the target holds ACK low
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b0 : ((8'h42 >> i) & 8'h01) != 0);
        m_low = 1'b0;
        @(negedge clk);
        check("r6_ack_driven", sda, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("r6_sda_released", sda, 1'b1);
        @(negedge clk);
        check("r6_busy_cleared", busy, 1'b0);
        reset = 1'b0;
        i2c_stop();
        dbg_read(8'h12, rd);
        check("r6_regfile_cleared", rd, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
